// File: rtl/unimon_pkg.sv
// unimon_pkg
//   Shared definitions for the unimon egress path: packet flag encodings,
//   ctrl-bus opcodes and address field positions, the egress input FSM
//   state type, ctrl word indices and a saturating counter helper.
package unimon_pkg;

  localparam int PKT_W = 134;

  // Packet word flag field, pkt[133:132]
  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_BODY = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  // ctrl_opt encodings (2'd2 is ignored)
  localparam logic [1:0] CTRL_OPT_CLEAR = 2'd0;
  localparam logic [1:0] CTRL_OPT_WRITE = 2'd1;
  localparam logic [1:0] CTRL_OPT_READ  = 2'd3;

  // ctrl_addr = {8'd0, tb_id[3:0], index[15:0], word[3:0]}
  localparam int CTRL_ZERO_HI = 31;
  localparam int CTRL_ZERO_LO = 24;
  localparam int CTRL_TB_HI   = 23;
  localparam int CTRL_TB_LO   = 20;
  localparam int CTRL_IDX_HI  = 19;
  localparam int CTRL_IDX_LO  = 4;
  localparam int CTRL_WORD_HI = 3;
  localparam int CTRL_WORD_LO = 0;

  // Egress input FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } egr_state_e;

  // ctrl word indices
  localparam logic [3:0] CW_PKT_IN  = 4'd0;
  localparam logic [3:0] CW_PKT_OUT = 4'd1;
  localparam logic [3:0] CW_DROP    = 4'd2;
  localparam logic [3:0] CW_OCC     = 4'd3;
  localparam logic [3:0] CW_CTRL    = 4'd4;
  localparam logic [3:0] CW_ERR     = 4'd5;

  // Add a small increment to a 32b counter, pinning at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'd0, inc};
    sat_add = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/unimon_sdp_ram.sv
// unimon_sdp_ram
//   Simple dual-port RAM, one write port and one read port, registered
//   read data (1-cycle latency). Read data holds while rd_en is low.
// Ports
//   clk      clock
//   wr_en    write strobe;  wr_addr / wr_data  write address / data
//   rd_en    read strobe;   rd_addr            read address
//   rd_data  registered read data
module unimon_sdp_ram #(
  parameter int WIDTH      = 134,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_r [0:(2**DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rd_data_r;

  // Storage array write and registered read; no reset on the array itself
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/unimon_egress_buf.sv
// unimon_egress_buf
//   Store-and-forward packet buffer behind unimon_top. Accepts the
//   un-throttled 134b packet stream, writes words tentatively and commits a
//   packet only when its tail lands, so the valid/ready output only ever
//   sees complete packets. Packets are dropped whole on overflow or while
//   disabled. Counters and the enable bit sit on the shared ctrl bus.
// Ports
//   clk, reset (async, active-low)
//   pkt_in_valid / pkt_in            input stream, no backpressure
//   pkt_out_valid / pkt_out / pkt_out_ready   output stream
//   ctrl_in_valid / ctrl_opt / ctrl_addr / ctrl_data_in   ctrl request
//   ctrl_out_valid / ctrl_data_out   ctrl read response
// Build option
//   UNIMON_EGRESS_ERR_CNT_EN: when defined, framing errors have their own
//   counter at word 5; otherwise they are counted in drop_cnt and word 5
//   reads 0.
module unimon_egress_buf
  import unimon_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [3:0] CTRL_TB_ID = 4'd3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pkt_in_valid,
  input  logic [133:0] pkt_in,
  output logic         pkt_out_valid,
  output logic [133:0] pkt_out,
  input  logic         pkt_out_ready,
  input  logic         ctrl_in_valid,
  input  logic [1:0]   ctrl_opt,
  input  logic [31:0]  ctrl_addr,
  input  logic [31:0]  ctrl_data_in,
  output logic         ctrl_out_valid,
  output logic [31:0]  ctrl_data_out
);

  localparam int AW = DEPTH_LOG2;

  egr_state_e        state_r, state_nxt_s;
  logic [AW-1:0]     wr_tent_r, wr_cmt_r, rd_ptr_r, rd_fetch_r;
  logic [AW-1:0]     tent_nxt_s, cmt_nxt_s, wr_addr_s, occ_s;
  logic              in_word_s, is_head_s, is_tail_s;
  logic              full_tent_s, full_cmt_s;
  logic              wr_en_s, drop_ev_s, err_ev_s, pkt_in_ev_s, pkt_out_ev_s;
  logic              enable_r;
  logic              rd_en_s, ram_vld_r, move_s, accept_s;
  logic [PKT_W-1:0]  ram_q_s;
  logic              pkt_out_valid_r;
  logic [PKT_W-1:0]  pkt_out_r;
  logic [31:0]       pkt_in_cnt_r, pkt_out_cnt_r, drop_cnt_r;
  logic [1:0]        drop_inc_s;
  logic              ctrl_sel_s, clr_s, wr_ctrl_s, rd_s;
  logic [3:0]        ctrl_word_s;
  logic [31:0]       rd_mux_s;
  logic              ctrl_out_valid_r;
  logic [31:0]       ctrl_data_out_r;
  logic              unused_s;

  // ---------------------------------------------------------------- input
  assign in_word_s = pkt_in_valid && (pkt_in[133:132] != FLAG_NONE);
  assign is_head_s = (pkt_in[133:132] == FLAG_HEAD);
  assign is_tail_s = (pkt_in[133:132] == FLAG_TAIL);
  // rd_ptr is the oldest un-accepted word, so prefetched words stay protected
  assign full_tent_s = ((wr_tent_r + AW'(1)) == rd_ptr_r);
  assign full_cmt_s  = ((wr_cmt_r + AW'(1)) == rd_ptr_r);

  // Next-state and write decode; a head always restarts from the committed pointer
  always_comb begin
    state_nxt_s = state_r;
    tent_nxt_s  = wr_tent_r;
    cmt_nxt_s   = wr_cmt_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_tent_r;
    drop_ev_s   = 1'b0;
    err_ev_s    = 1'b0;
    pkt_in_ev_s = 1'b0;
    if (!in_word_s) begin
      state_nxt_s = state_r;
    end else if (is_head_s) begin
      // A head outside IDLE means the previous packet lost its tail
      err_ev_s = (state_r != IDLE);
      if (enable_r && !full_cmt_s) begin
        wr_en_s     = 1'b1;
        wr_addr_s   = wr_cmt_r;
        tent_nxt_s  = wr_cmt_r + AW'(1);
        state_nxt_s = RECV;
      end else begin
        drop_ev_s   = 1'b1;
        tent_nxt_s  = wr_cmt_r;
        state_nxt_s = DROP;
      end
    end else begin
      case (state_r)
        IDLE: begin
          err_ev_s = 1'b1;
        end
        RECV: begin
          if (full_tent_s) begin
            tent_nxt_s  = wr_cmt_r;
            drop_ev_s   = 1'b1;
            state_nxt_s = DROP;
          end else begin
            wr_en_s    = 1'b1;
            tent_nxt_s = wr_tent_r + AW'(1);
            if (is_tail_s) begin
              cmt_nxt_s   = wr_tent_r + AW'(1);
              pkt_in_ev_s = 1'b1;
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = RECV;
            end
          end
        end
        DROP: begin
          if (is_tail_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DROP;
          end
        end
        default: begin
          tent_nxt_s  = wr_cmt_r;
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Input FSM state and write pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      wr_tent_r <= '0;
      wr_cmt_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      wr_tent_r <= tent_nxt_s;
      wr_cmt_r  <= cmt_nxt_s;
    end
  end

  unimon_sdp_ram #(
    .WIDTH      (PKT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (pkt_in),
    .rd_en   (rd_en_s),
    .rd_addr (rd_fetch_r),
    .rd_data (ram_q_s)
  );

  // --------------------------------------------------------------- output
  // Two holding slots: RAM read register and output register. A read is
  // issued only when the RAM slot will be free, giving 1 word/clk.
  assign accept_s     = pkt_out_valid_r && pkt_out_ready;
  assign move_s       = ram_vld_r && (!pkt_out_valid_r || accept_s);
  assign rd_en_s      = (rd_fetch_r != wr_cmt_r) && (!ram_vld_r || move_s);
  assign pkt_out_ev_s = accept_s && (pkt_out_r[133:132] == FLAG_TAIL);

  // Read pipeline: fetch pointer, RAM slot valid, output register, accept pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_fetch_r      <= '0;
      rd_ptr_r        <= '0;
      ram_vld_r       <= 1'b0;
      pkt_out_valid_r <= 1'b0;
      pkt_out_r       <= '0;
    end else begin
      if (rd_en_s) begin
        rd_fetch_r <= rd_fetch_r + AW'(1);
        ram_vld_r  <= 1'b1;
      end else if (move_s) begin
        ram_vld_r  <= 1'b0;
      end
      if (move_s) begin
        pkt_out_valid_r <= 1'b1;
        pkt_out_r       <= ram_q_s;
      end else if (accept_s) begin
        pkt_out_valid_r <= 1'b0;
        pkt_out_r       <= '0;
      end
      if (accept_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  assign pkt_out_valid = pkt_out_valid_r;
  assign pkt_out       = pkt_out_r;
  assign occ_s         = wr_cmt_r - rd_ptr_r;

  // ----------------------------------------------------------------- ctrl
  assign ctrl_sel_s  = ctrl_in_valid
                    && (ctrl_addr[CTRL_ZERO_HI:CTRL_ZERO_LO] == 8'd0)
                    && (ctrl_addr[CTRL_TB_HI:CTRL_TB_LO] == CTRL_TB_ID);
  assign ctrl_word_s = ctrl_addr[CTRL_WORD_HI:CTRL_WORD_LO];
  assign clr_s       = ctrl_sel_s && (ctrl_opt == CTRL_OPT_CLEAR);
  assign wr_ctrl_s   = ctrl_sel_s && (ctrl_opt == CTRL_OPT_WRITE) && (ctrl_word_s == CW_CTRL);
  assign rd_s        = ctrl_sel_s && (ctrl_opt == CTRL_OPT_READ);
  assign unused_s    = ^{ctrl_data_in[31:1], ctrl_addr[CTRL_IDX_HI:CTRL_IDX_LO]};

`ifdef UNIMON_EGRESS_ERR_CNT_EN
  logic [31:0] err_cnt_r;
  assign drop_inc_s = {1'b0, drop_ev_s};

  // Framing error counter; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_r <= 32'd0;
    end else if (clr_s) begin
      err_cnt_r <= 32'd0;
    end else begin
      err_cnt_r <= sat_add(err_cnt_r, {1'b0, err_ev_s});
    end
  end
`else
  // Framing errors fold into the drop counter
  assign drop_inc_s = {1'b0, drop_ev_s} + {1'b0, err_ev_s};
`endif

  // Packet and drop counters; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_in_cnt_r  <= 32'd0;
      pkt_out_cnt_r <= 32'd0;
      drop_cnt_r    <= 32'd0;
    end else if (clr_s) begin
      pkt_in_cnt_r  <= 32'd0;
      pkt_out_cnt_r <= 32'd0;
      drop_cnt_r    <= 32'd0;
    end else begin
      pkt_in_cnt_r  <= sat_add(pkt_in_cnt_r, {1'b0, pkt_in_ev_s});
      pkt_out_cnt_r <= sat_add(pkt_out_cnt_r, {1'b0, pkt_out_ev_s});
      drop_cnt_r    <= sat_add(drop_cnt_r, drop_inc_s);
    end
  end

  // Enable bit, written through ctrl word 4
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_r <= 1'b1;
    end else if (wr_ctrl_s) begin
      enable_r <= ctrl_data_in[0];
    end
  end

  // Read-data select by word index
  always_comb begin
    rd_mux_s = 32'd0;
    case (ctrl_word_s)
      CW_PKT_IN:  rd_mux_s = pkt_in_cnt_r;
      CW_PKT_OUT: rd_mux_s = pkt_out_cnt_r;
      CW_DROP:    rd_mux_s = drop_cnt_r;
      CW_OCC:     rd_mux_s = {{(32-AW){1'b0}}, occ_s};
      CW_CTRL:    rd_mux_s = {31'd0, enable_r};
`ifdef UNIMON_EGRESS_ERR_CNT_EN
      CW_ERR:     rd_mux_s = err_cnt_r;
`else
      CW_ERR:     rd_mux_s = 32'd0;
`endif
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Registered one-cycle read response; data is 0 outside the response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_out_valid_r <= 1'b0;
      ctrl_data_out_r  <= 32'd0;
    end else begin
      ctrl_out_valid_r <= rd_s;
      ctrl_data_out_r  <= rd_s ? rd_mux_s : 32'd0;
    end
  end

  assign ctrl_out_valid = ctrl_out_valid_r;
  assign ctrl_data_out  = ctrl_data_out_r;

endmodule

// File: tb/tb_unimon_egress_buf.sv
// tb_unimon_egress_buf
//   Directed bench. Two instances share all inputs: dut (DEPTH_LOG2=8) and
//   dut_s (DEPTH_LOG2=3, 7-word capacity) for the overflow scenario.
`timescale 1ns/1ps
module tb_unimon_egress_buf;

  localparam logic [1:0] F_HEAD = 2'b01;
  localparam logic [1:0] F_BODY = 2'b11;
  localparam logic [1:0] F_TAIL = 2'b10;
`ifdef UNIMON_EGRESS_ERR_CNT_EN
  localparam logic [31:0] ERR_ONE = 32'd1;
`else
  localparam logic [31:0] ERR_ONE = 32'd0;
`endif
  // a single framing error lands in drop_cnt when err_cnt is not built
  localparam logic [31:0] ERR_DROP = 32'd1 - ERR_ONE;

  localparam logic [127:0] BASE_A = {32'd0, 32'd2, 32'd1, 16'd4, 16'd3};
  localparam logic [127:0] BASE_B = 128'hB000_0000_0000_0000_0000_0000_0000_0100;
  localparam logic [127:0] BASE_C = 128'hC000_0000_0000_0000_0000_0000_0000_0200;
  localparam logic [127:0] BASE_D = 128'hD000_0000_0000_0000_0000_0000_0000_0300;

  logic         clk = 1'b0;
  logic         reset;
  logic         pkt_in_valid;
  logic [133:0] pkt_in;
  logic         pkt_out_ready;
  logic         ctrl_in_valid;
  logic [1:0]   ctrl_opt;
  logic [31:0]  ctrl_addr, ctrl_data_in;
  logic         pkt_out_valid, s_pkt_out_valid;
  logic [133:0] pkt_out, s_pkt_out;
  logic         ctrl_out_valid, s_ctrl_out_valid;
  logic [31:0]  ctrl_data_out, s_ctrl_data_out;

  int checks = 0;
  int errors = 0;
  logic [133:0] rx_q[$];
  logic [133:0] s_rx_q[$];
  logic         rv, srv;
  logic [31:0]  rd, srd;

  always #5 clk = ~clk;

  unimon_egress_buf dut (
    .clk(clk), .reset(reset), .pkt_in_valid(pkt_in_valid), .pkt_in(pkt_in),
    .pkt_out_valid(pkt_out_valid), .pkt_out(pkt_out), .pkt_out_ready(pkt_out_ready),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_opt(ctrl_opt), .ctrl_addr(ctrl_addr),
    .ctrl_data_in(ctrl_data_in), .ctrl_out_valid(ctrl_out_valid), .ctrl_data_out(ctrl_data_out)
  );

  unimon_egress_buf #(.DEPTH_LOG2(3)) dut_s (
    .clk(clk), .reset(reset), .pkt_in_valid(pkt_in_valid), .pkt_in(pkt_in),
    .pkt_out_valid(s_pkt_out_valid), .pkt_out(s_pkt_out), .pkt_out_ready(pkt_out_ready),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_opt(ctrl_opt), .ctrl_addr(ctrl_addr),
    .ctrl_data_in(ctrl_data_in), .ctrl_out_valid(s_ctrl_out_valid), .ctrl_data_out(s_ctrl_data_out)
  );

  // Collect accepted output words, sampled mid-cycle
  always @(negedge clk) begin
    if (pkt_out_valid && pkt_out_ready) rx_q.push_back(pkt_out);
    if (s_pkt_out_valid && pkt_out_ready) s_rx_q.push_back(s_pkt_out);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [133:0] pkt_word(input logic [127:0] base, input int i, input int n);
    logic [1:0] f;
    if (i == 0) f = F_HEAD; else if (i == n - 1) f = F_TAIL; else f = F_BODY;
    return {f, 4'(i), base + 128'(i)};
  endfunction

  task automatic drive_word(input logic [133:0] w);
    pkt_in_valid = 1'b1; pkt_in = w;
    tick();
    pkt_in_valid = 1'b0; pkt_in = 134'd0;
  endtask

  task automatic send_pkt(input logic [127:0] base, input int n);
    for (int i = 0; i < n; i++) drive_word(pkt_word(base, i, n));
  endtask

  task automatic ctrl_op(input logic [1:0] opt, input logic [3:0] tb, input logic [3:0] word, input logic [31:0] d);
    ctrl_in_valid = 1'b1; ctrl_opt = opt; ctrl_addr = {8'd0, tb, 16'h00A5, word}; ctrl_data_in = d;
    tick();
    ctrl_in_valid = 1'b0; ctrl_opt = 2'd2; ctrl_addr = 32'd0; ctrl_data_in = 32'd0;
  endtask

  // Issue a read and capture both instances' responses in the response cycle
  task automatic ctrl_read(input logic [3:0] tb, input logic [3:0] word);
    ctrl_op(2'd3, tb, word, 32'd0);
    rv = ctrl_out_valid; rd = ctrl_data_out; srv = s_ctrl_out_valid; srd = s_ctrl_data_out;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(2); reset = 1'b1; tick();
    rx_q.delete(); s_rx_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; pkt_in_valid = 1'b0; pkt_in = 134'd0; pkt_out_ready = 1'b1;
    ctrl_in_valid = 1'b0; ctrl_opt = 2'd2; ctrl_addr = 32'd0; ctrl_data_in = 32'd0;
    tick(2);
    checks++; if (pkt_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", pkt_out_valid); end
    checks++; if (pkt_out !== 134'd0) begin errors++; $display("FAIL rst_pkt_out got %0h exp 0", pkt_out); end
    checks++; if (ctrl_out_valid !== 1'b0 || ctrl_data_out !== 32'd0) begin errors++; $display("FAIL rst_ctrl got %0h/%0h exp 0/0", ctrl_out_valid, ctrl_data_out); end
    reset = 1'b1; tick();
    ctrl_read(4'd3, 4'd4);
    checks++; if (rv !== 1'b1 || rd !== 32'd1) begin errors++; $display("FAIL rst_enable got %0h/%0h exp 1/1", rv, rd); end
    checks++; if (ctrl_out_valid !== 1'b0 || ctrl_data_out !== 32'd0) begin errors++; $display("FAIL resp_one_clk got %0h/%0h exp 0/0", ctrl_out_valid, ctrl_data_out); end
    ctrl_read(4'd3, 4'd3);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", rd); end
  endtask

  task automatic test_single();
    do_reset(); pkt_out_ready = 1'b1;
    send_pkt(BASE_A, 5);
    checks++; if (pkt_out_valid !== 1'b0) begin errors++; $display("FAIL lat_t0 got %0h exp 0", pkt_out_valid); end
    tick();
    checks++; if (pkt_out_valid !== 1'b0) begin errors++; $display("FAIL lat_t1 got %0h exp 0", pkt_out_valid); end
    tick();
    checks++; if (pkt_out_valid !== 1'b1) begin errors++; $display("FAIL lat_t2 got %0h exp 1", pkt_out_valid); end
    tick(6);
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL single_count got %0d exp 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== pkt_word(BASE_A, i, 5)) begin
        errors++; $display("FAIL single_word%0d got %0h exp %0h", i, (i < rx_q.size()) ? rx_q[i] : 134'd0, pkt_word(BASE_A, i, 5));
      end
    end
    ctrl_read(4'd3, 4'd0);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL single_pkt_in got %0d exp 1", rd); end
    ctrl_read(4'd3, 4'd1);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL single_pkt_out got %0d exp 1", rd); end
  endtask

  task automatic test_backpressure();
    logic [133:0] e;
    do_reset(); pkt_out_ready = 1'b0;
    send_pkt(BASE_A, 5); send_pkt(BASE_B, 5);
    tick(4);
    ctrl_read(4'd3, 4'd3);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL bp_occ_before got %0d exp 10", rd); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL bp_no_accept got %0d exp 0", rx_q.size()); end
    checks++; if (pkt_out_valid !== 1'b1 || pkt_out !== pkt_word(BASE_A, 0, 5)) begin errors++; $display("FAIL bp_hold got %0h/%0h exp 1/%0h", pkt_out_valid, pkt_out, pkt_word(BASE_A, 0, 5)); end
    pkt_out_ready = 1'b1;
    tick(15);
    checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL bp_count got %0d exp 10", rx_q.size()); end
    for (int i = 0; i < 10; i++) begin
      e = (i < 5) ? pkt_word(BASE_A, i, 5) : pkt_word(BASE_B, i - 5, 5);
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== e) begin
        errors++; $display("FAIL bp_word%0d got %0h exp %0h", i, (i < rx_q.size()) ? rx_q[i] : 134'd0, e);
      end
    end
    ctrl_read(4'd3, 4'd3);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL bp_occ_after got %0d exp 0", rd); end
    ctrl_read(4'd3, 4'd1);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL bp_pkt_out got %0d exp 2", rd); end
  endtask

  task automatic test_overflow();
    do_reset(); pkt_out_ready = 1'b0;
    send_pkt(BASE_A, 5); send_pkt(BASE_B, 5);
    tick(4);
    ctrl_read(4'd3, 4'd2);
    checks++; if (srd !== 32'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", srd); end
    ctrl_read(4'd3, 4'd3);
    checks++; if (srd !== 32'd5) begin errors++; $display("FAIL ovf_occ got %0d exp 5", srd); end
    pkt_out_ready = 1'b1;
    tick(15);
    checks++; if (s_rx_q.size() != 5) begin errors++; $display("FAIL ovf_count got %0d exp 5", s_rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= s_rx_q.size() || s_rx_q[i] !== pkt_word(BASE_A, i, 5)) begin
        errors++; $display("FAIL ovf_word%0d got %0h exp %0h", i, (i < s_rx_q.size()) ? s_rx_q[i] : 134'd0, pkt_word(BASE_A, i, 5));
      end
    end
  endtask

  task automatic test_framing();
    do_reset(); pkt_out_ready = 1'b1;
    drive_word(pkt_word(BASE_C, 0, 5)); drive_word(pkt_word(BASE_C, 1, 5));
    send_pkt(BASE_D, 3);
    tick(8);
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL frm_count got %0d exp 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== pkt_word(BASE_D, i, 3)) begin
        errors++; $display("FAIL frm_word%0d got %0h exp %0h", i, (i < rx_q.size()) ? rx_q[i] : 134'd0, pkt_word(BASE_D, i, 3));
      end
    end
    ctrl_read(4'd3, 4'd5);
    checks++; if (rd !== ERR_ONE) begin errors++; $display("FAIL frm_err got %0d exp %0d", rd, ERR_ONE); end
    ctrl_read(4'd3, 4'd2);
    checks++; if (rd !== ERR_DROP) begin errors++; $display("FAIL frm_drop got %0d exp %0d", rd, ERR_DROP); end
  endtask

  task automatic test_enable_ctrl();
    do_reset(); pkt_out_ready = 1'b1;
    ctrl_op(2'd1, 4'd3, 4'd4, 32'd0);
    ctrl_read(4'd3, 4'd4);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL en_write0 got %0d exp 0", rd); end
    send_pkt(BASE_C, 4);
    tick(6);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL en_nothing_out got %0d exp 0", rx_q.size()); end
    ctrl_read(4'd3, 4'd2);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL en_drop got %0d exp 1", rd); end
    ctrl_op(2'd1, 4'd3, 4'd4, 32'd1);
    send_pkt(BASE_D, 4);
    tick(8);
    checks++; if (rx_q.size() != 4 || rx_q[3] !== pkt_word(BASE_D, 3, 4)) begin errors++; $display("FAIL en_pass got %0d words exp 4", rx_q.size()); end
    ctrl_op(2'd1, 4'd3, 4'd0, 32'd77);
    ctrl_read(4'd3, 4'd0);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL en_wr_ignored got %0d exp 1", rd); end
    ctrl_read(4'd3, 4'd7);
    checks++; if (rv !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL unmapped got %0h/%0d exp 1/0", rv, rd); end
    ctrl_read(4'd2, 4'd0);
    checks++; if (rv !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wrong_tb got %0h/%0d exp 0/0", rv, rd); end
    ctrl_op(2'd0, 4'd3, 4'd0, 32'd0);
    for (int w = 0; w < 3; w++) begin
      ctrl_read(4'd3, 4'(w));
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL clear_word%0d got %0d exp 0", w, rd); end
    end
    ctrl_read(4'd3, 4'd4);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL clear_keeps_en got %0d exp 1", rd); end
  endtask

  task automatic test_reset_mid();
    do_reset(); pkt_out_ready = 1'b0;
    send_pkt(BASE_A, 3);
    drive_word(pkt_word(BASE_B, 0, 3)); drive_word(pkt_word(BASE_B, 1, 3));
    checks++; if (pkt_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0h exp 1", pkt_out_valid); end
    reset = 1'b0; tick();
    checks++; if (pkt_out_valid !== 1'b0 || pkt_out !== 134'd0) begin errors++; $display("FAIL mid_rst_out got %0h/%0h exp 0/0", pkt_out_valid, pkt_out); end
    reset = 1'b1; tick();
    rx_q.delete(); pkt_out_ready = 1'b1;
    drive_word(pkt_word(BASE_B, 2, 3));
    send_pkt(BASE_C, 3);
    tick(8);
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL mid_count got %0d exp 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== pkt_word(BASE_C, i, 3)) begin
        errors++; $display("FAIL mid_word%0d got %0h exp %0h", i, (i < rx_q.size()) ? rx_q[i] : 134'd0, pkt_word(BASE_C, i, 3));
      end
    end
    ctrl_read(4'd3, 4'd5);
    checks++; if (rd !== ERR_ONE) begin errors++; $display("FAIL mid_err got %0d exp %0d", rd, ERR_ONE); end
    ctrl_read(4'd3, 4'd2);
    checks++; if (rd !== ERR_DROP) begin errors++; $display("FAIL mid_drop got %0d exp %0d", rd, ERR_DROP); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_framing();
    test_enable_ctrl();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
